alu_pipe: RTL

Parametrised, two-stage pipelined successor to the combinational ARM ALU. It executes the same 5-bit opcode set (16 ARM data-processing ops plus the nine auxiliary address ops) at a configurable datapath width. It owns an architectural NZCV flag register, so ADC/SBC/RSC take their carry from that register rather than from an external pin. Operands enter and results leave through valid/ready handshakes, so the block sits between the register-read stage and writeback with back-pressure.

---
 rtl/alu_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ARM-style ALU with an architectural NZCV register.
// S1 latches operands; execution runs from S1 and lands in S2 with the flag update.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int OFFSET = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    input  logic             s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             wr,
    output logic             illegal,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

    localparam logic [4:0] OP_AND = 5'b00000, OP_EOR = 5'b00001, OP_SUB = 5'b00010,
                           OP_RSB = 5'b00011, OP_ADD = 5'b00100, OP_ADC = 5'b00101,
                           OP_SBC = 5'b00110, OP_RSC = 5'b00111, OP_TST = 5'b01000,
                           OP_TEQ = 5'b01001, OP_CMP = 5'b01010, OP_CMN = 5'b01011,
                           OP_ORR = 5'b01100, OP_MOV = 5'b01101, OP_BIC = 5'b01110,
                           OP_MVN = 5'b01111, OP_X1  = 5'b10000, OP_X2  = 5'b10001,
                           OP_X3  = 5'b10010, OP_X4  = 5'b10011, OP_X5  = 5'b10100,
                           OP_X6  = 5'b10101, OP_X7  = 5'b10110, OP_X8  = 5'b11001,
                           OP_X9  = 5'b11010;

    logic             r_s1_valid, r_s2_valid;
    logic [WIDTH-1:0] r_a, r_b;
    logic [4:0]       r_op;
    logic             r_s;
    logic [WIDTH-1:0] r_r;
    logic             r_wr, r_illegal;
    logic             r_n, r_z, r_c, r_v;

    logic             w_s1_adv, w_xfer, w_accept;
    logic [WIDTH-1:0] w_x, w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_wr, w_ill, w_arith, w_upd;

    assign w_s1_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_s1_valid && w_s1_adv;

    // Subtracts are add-of-complement, so the adder carry-out is the ARM "no borrow" C.
    always_comb begin
        w_x   = r_a;
        w_y   = r_b;
        w_cin = 1'b0;
        case (r_op)
            OP_SUB, OP_CMP: begin w_y = ~r_b; w_cin = 1'b1; end
            OP_SBC:         begin w_y = ~r_b; w_cin = r_c;  end
            OP_RSB:         begin w_x = r_b; w_y = ~r_a; w_cin = 1'b1; end
            OP_RSC:         begin w_x = r_b; w_y = ~r_a; w_cin = r_c;  end
            OP_ADC:         w_cin = r_c;
            default:        w_cin = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

    always_comb begin
        w_res   = '0;
        w_wr    = 1'b1;
        w_ill   = 1'b0;
        w_arith = 1'b0;
        case (r_op)
            OP_AND, OP_TST: w_res = r_a & r_b;
            OP_EOR, OP_TEQ: w_res = r_a ^ r_b;
            OP_ORR:         w_res = r_a | r_b;
            OP_MOV:         w_res = r_b;
            OP_BIC:         w_res = r_a & ~r_b;
            OP_MVN:         w_res = ~r_b;
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN: begin
                w_res   = w_sum[WIDTH-1:0];
                w_arith = 1'b1;
            end
            OP_X1:   w_res = r_b;
            OP_X2:   w_res = r_b + OFF;
            OP_X3:   w_res = r_a + r_b + OFF;
            OP_X4:   w_res = r_b - OFF;
            OP_X5:   w_res = r_a - OFF;
            OP_X6:   w_res = r_a + r_b;
            OP_X7:   w_res = r_b - r_a;
            OP_X8:   w_res = r_a;
            OP_X9:   w_res = r_a + OFF;
            default: begin w_wr = 1'b0; w_ill = 1'b1; end
        endcase
        if (r_op[4:2] == 3'b010)
            w_wr = 1'b0;
    end

    // Auxiliary and illegal opcodes all have op[4] set, so they never update flags.
    assign w_upd = !r_op[4] && (r_s || r_op[4:2] == 3'b010);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_s        <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= op;
                r_s  <= s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_r        <= '0;
            r_wr       <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_r       <= w_res;
                r_wr      <= w_wr;
                r_illegal <= w_ill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if (w_xfer && w_upd) begin
            r_n <= w_res[WIDTH-1];
            r_z <= (w_res == '0);
            if (w_arith) begin
                r_c <= w_sum[WIDTH];
                r_v <= w_ovf;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign r         = r_r;
    assign wr        = r_wr;
    assign illegal   = r_illegal;
    assign n         = r_n;
    assign z         = r_z;
    assign c         = r_c;
    assign v         = r_v;

endmodule
